// File: rtl/loader_pkg.sv
// Shared parameters and types for the activation stream loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loader_pkg;

    localparam int LD_DATA_W = 16;
    localparam int LD_ROWS   = 32;
    localparam int LD_AXI_W  = 64;
    localparam int LD_EPB    = LD_AXI_W / LD_DATA_W;  // elements per beat
    localparam int LD_BPV    = LD_ROWS / LD_EPB;      // beats per vector

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } rd_state_e;

    // One column vector: ROWS elements, element r at index r.
    typedef logic [LD_ROWS-1:0][LD_DATA_W-1:0] vec_t;

endpackage

// File: rtl/act_stream_loader_if.sv
// Bundles the AXI-Stream input beat and the vector output handshake of the loader.
// Latency: n/a (wiring only).
// Backpressure: s_axis_tready toward the source, vec_ready from the skew array.
interface act_stream_loader_if
    import loader_pkg::*;
#(
    parameter int DATA_W = LD_DATA_W,
    parameter int ROWS   = LD_ROWS,
    parameter int AXI_W  = LD_AXI_W
);
    logic [AXI_W-1:0]  s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;
    logic [DATA_W-1:0] vec_out [ROWS-1:0];
    logic              vec_vld;
    logic              vec_ready;

    // Loader side.
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, vec_ready,
        output s_axis_tready, vec_out, vec_vld
    );

    // Source / sink side.
    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, vec_ready,
        input  s_axis_tready, vec_out, vec_vld
    );
endinterface

// File: rtl/vec_pingpong.sv
// Two-slot vector store with a tlast tag per slot and a retag port for the newest slot.
// Latency: a push is readable on rd_dat the cycle after it is written.
// Backpressure: none internally; the caller must not push when cnt == 2 or pop when cnt == 0.
module vec_pingpong #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 32
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          push,
    input  logic [ROWS-1:0][DATA_W-1:0]   push_dat,
    input  logic                          push_last,
    input  logic                          pop,
    input  logic                          retag,
    output logic [ROWS-1:0][DATA_W-1:0]   rd_dat,
    output logic                          rd_last,
    output logic                          last_tag,
    output logic [1:0]                    cnt
);

    logic [ROWS-1:0][DATA_W-1:0] slot [2];
    logic [1:0]                  tag;
    logic                        wr_ptr;
    logic                        rd_ptr;
    logic [1:0]                  cnt_q;

    // Pointers, fill count and tags; reset empties the store.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
            tag    <= 2'b00;
        end else begin
            if (push) begin
                wr_ptr      <= ~wr_ptr;
                tag[wr_ptr] <= push_last;
            end
            // Retag never coincides with a push: it only follows a dropped short beat.
            if (retag) begin
                tag[~wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Slot payload; occupancy is tracked by cnt_q so the data needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            slot[wr_ptr] <= push_dat;
        end
    end

    assign rd_dat   = slot[rd_ptr];
    assign rd_last  = tag[rd_ptr];
    assign last_tag = tag[~wr_ptr];
    assign cnt      = cnt_q;

endmodule

// File: rtl/act_stream_loader.sv
// Unpacks AXI-Stream beats into ROWS-wide vectors, ping-pong buffers them, and appends ROWS-1 zero vectors per tile.
// Latency: beat accepted at cycle t that completes a vector -> vec_vld at t+1.
// Backpressure: s_axis_tready low while both slots are full (registered, no path from vec_ready); vec_ready low holds outputs.
// Build option LOADER_SHORT_PAD_EN: zero-pad and emit a vector cut short by tlast instead of dropping it.
module act_stream_loader
    import loader_pkg::*;
#(
    parameter int DATA_W = LD_DATA_W,
    parameter int ROWS   = LD_ROWS,
    parameter int AXI_W  = LD_AXI_W
) (
    input  logic                clk,
    input  logic                nrst,
    act_stream_loader_if.slave  bus,
    output logic                tile_done,
    output logic                err_short
);

    localparam int EPB = AXI_W / DATA_W;
    localparam int BPV = ROWS / EPB;
    localparam int BCW = (BPV > 1) ? $clog2(BPV) : 1;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef logic [ROWS-1:0][DATA_W-1:0] lvec_t;

    // Write side
    logic            init_q;
    logic            tready;
    logic            accept;
    logic            last_beat;
    logic            end_vec;
    logic            short_last;
    logic [BCW-1:0]  beat_cnt;
    lvec_t           accum;
    lvec_t           merged;
    logic            push;
    logic            retag;
    logic            drain_set;
    logic            drain_clr;
    logic            drain_req;
    logic            err_q;

    // Store
    lvec_t           rd_dat;
    logic            rd_last;
    logic            last_tag;
    logic [1:0]      cnt;

    // Read side
    rd_state_e       state_q;
    rd_state_e       state_d;
    logic [RW-1:0]   drain_cnt_q;
    logic [RW-1:0]   drain_cnt_d;
    logic            pop;
    logic            vld;
    logic            show;
    logic            done;

    // tready comes from registers only; init_q keeps it low while in reset.
    assign tready             = init_q && (cnt != 2'd2);
    assign bus.s_axis_tready  = tready;
    assign accept             = bus.s_axis_tvalid && tready;
    assign last_beat          = (beat_cnt == BCW'(BPV - 1));
    assign end_vec            = last_beat || bus.s_axis_tlast;
    assign short_last         = accept && bus.s_axis_tlast && !last_beat;

`ifdef LOADER_SHORT_PAD_EN
    assign push      = accept && end_vec;
    assign retag     = 1'b0;
    assign drain_set = 1'b0;
`else
    logic can_retag;
    // The newest committed slot must still be in the store after this cycle's pop and not already close a tile.
    assign can_retag = ((cnt == 2'd2) || ((cnt == 2'd1) && !pop)) && !last_tag;
    assign push      = accept && last_beat;
    assign retag     = short_last && can_retag;
    assign drain_set = short_last && !can_retag;
`endif

    // Current beat merged over the partial vector; rows not yet written stay zero.
    always_comb begin
        merged = accum;
        for (int k = 0; k < EPB; k++) begin
            merged[RW'(int'(beat_cnt) * EPB + k)] = bus.s_axis_tdata[k*DATA_W +: DATA_W];
        end
    end

    // Beat counter and partial-vector accumulator; cleared whenever a vector ends.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            beat_cnt <= '0;
            accum    <= '0;
        end else if (accept) begin
            if (end_vec) begin
                beat_cnt <= '0;
                accum    <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
                accum    <= merged;
            end
        end
    end

    // Ready enable, sticky short-tile error and pending drain for a tile with no committed vector.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            init_q    <= 1'b0;
            err_q     <= 1'b0;
            drain_req <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (short_last) begin
                err_q <= 1'b1;
            end
            if (drain_set) begin
                drain_req <= 1'b1;
            end else if (drain_clr) begin
                drain_req <= 1'b0;
            end
        end
    end

    vec_pingpong #(
        .DATA_W (DATA_W),
        .ROWS   (ROWS)
    ) u_store (
        .clk       (clk),
        .nrst      (nrst),
        .push      (push),
        .push_dat  (merged),
        .push_last (bus.s_axis_tlast),
        .pop       (pop),
        .retag     (retag),
        .rd_dat    (rd_dat),
        .rd_last   (rd_last),
        .last_tag  (last_tag),
        .cnt       (cnt)
    );

    // Read FSM state and drain counter registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Read FSM next state and outputs: stream stored vectors, then ROWS-1 zero vectors per tile.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        vld         = 1'b0;
        show        = 1'b0;
        pop         = 1'b0;
        done        = 1'b0;
        drain_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (drain_req && (cnt == 2'd0)) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                    drain_clr   = 1'b1;
                end else if ((cnt != 2'd0) || push) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (cnt != 2'd0) begin
                    vld  = 1'b1;
                    show = 1'b1;
                    if (bus.vec_ready) begin
                        pop = 1'b1;
                        if (rd_last) begin
                            state_d     = DRAIN;
                            drain_cnt_d = '0;
                        end
                    end
                end else if (drain_req) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                    drain_clr   = 1'b1;
                end
            end
            DRAIN: begin
                vld = 1'b1;
                if (bus.vec_ready) begin
                    if (drain_cnt_q == RW'(ROWS - 2)) begin
                        done = 1'b1;
                        // Go straight to streaming if the next tile is already buffered.
                        state_d = ((cnt != 2'd0) || push) ? STREAM : IDLE;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Vector output: stored slot while streaming, zeros otherwise.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            bus.vec_out[r] = show ? rd_dat[r] : '0;
        end
    end

    assign bus.vec_vld = vld;
    assign tile_done   = done;
    assign err_short   = err_q;

endmodule
